// File: rtl/sad2_absdiff_stage.sv
// rtl/sad2_absdiff_stage.sv - SAD stage 2: per-lane |a-b| with block accumulation (option: SAD2_SATURATE_EN)
module sad2_absdiff_stage #(
    parameter int BLOCK_ROWS = 16,
    parameter int ACC_W      = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        InValid,
    input  logic        SADOp,
    input  logic [31:0] WinA,
    input  logic [31:0] WinB,
    input  logic        RegWriteCtrl,
    input  logic [4:0]  RegDstResult,
    input  logic [31:0] PCPlus4,
    output logic        oValid,
    output logic        oSAD,
    output logic [31:0] oA2,
    output logic [31:0] oB2,
    output logic [31:0] oC2,
    output logic [31:0] oD2,
    output logic [7:0]  oRowIdx,
    output logic        oRegWriteCtrl,
    output logic [4:0]  oRegDstResult,
    output logic [31:0] oPCPlus4
);

    // Row index of the final row in a block; row counter is 8 bits since a block holds at most 256 rows.
    localparam logic [7:0] LAST_ROW = 8'(BLOCK_ROWS - 1);

    // Lane order inside a packed word: index 0 = A (top byte) .. index 3 = D (bottom byte).
    logic [7:0]       r_row;
    logic [ACC_W-1:0] r_acc  [4];
    logic [ACC_W-1:0] r_lane [4];
    logic             r_valid;
    logic             r_sad;
    logic [7:0]       r_row_idx;
    logic             r_reg_write;
    logic [4:0]       r_reg_dst;
    logic [31:0]      r_pc_plus4;

    logic [7:0]       w_diff [4];
    logic [ACC_W-1:0] w_base [4];
    logic [ACC_W-1:0] w_next [4];
    logic             w_last_row;

`ifdef SAD2_SATURATE_EN
    localparam int SUM_W = ACC_W + 1;
    logic [SUM_W-1:0] w_sum [4];
`endif

    // Unsigned byte distance: 9-bit subtract, then negate when the borrow bit is set.
    function automatic logic [7:0] abs_diff8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] d;
        d = {1'b0, a} - {1'b0, b};
        abs_diff8 = d[8] ? 8'(~d + 9'd1) : d[7:0];
    endfunction

    assign w_last_row = (r_row == LAST_ROW);

    // Per-lane difference and next running total; row 0 starts a fresh total from the diff alone.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_diff[i] = abs_diff8(WinA[31-8*i -: 8], WinB[31-8*i -: 8]);
            w_base[i] = (r_row == 8'd0) ? '0 : r_acc[i];
`ifdef SAD2_SATURATE_EN
            w_sum[i]  = {1'b0, w_base[i]} + SUM_W'(w_diff[i]);
            w_next[i] = w_sum[i][ACC_W] ? '1 : w_sum[i][ACC_W-1:0];
`else
            w_next[i] = w_base[i] + ACC_W'(w_diff[i]);
`endif
        end
    end

    // Pipeline register: reset beats flush beats stall beats accept.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_row       <= 8'd0;
            r_valid     <= 1'b0;
            r_sad       <= 1'b0;
            r_row_idx   <= 8'd0;
            r_reg_write <= 1'b0;
            r_reg_dst   <= 5'd0;
            r_pc_plus4  <= 32'd0;
            for (int i = 0; i < 4; i++) begin
                r_acc[i]  <= '0;
                r_lane[i] <= '0;
            end
        end else if (Flush) begin
            r_row   <= 8'd0;
            r_valid <= 1'b0;
            r_sad   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_acc[i]  <= '0;
                r_lane[i] <= '0;
            end
        end else if (!Stall) begin
            if (InValid) begin
                r_valid     <= 1'b1;
                r_reg_write <= RegWriteCtrl;
                r_reg_dst   <= RegDstResult;
                r_pc_plus4  <= PCPlus4;
                if (SADOp) begin
                    r_row_idx <= r_row;
                    r_sad     <= w_last_row;
                    r_row     <= w_last_row ? 8'd0 : r_row + 8'd1;
                    for (int i = 0; i < 4; i++) begin
                        r_acc[i]  <= w_next[i];
                        r_lane[i] <= w_next[i];
                    end
                end else begin
                    // Non-SAD instruction: lanes read zero but the block's totals survive.
                    r_sad <= 1'b0;
                    for (int i = 0; i < 4; i++) begin
                        r_lane[i] <= '0;
                    end
                end
            end else begin
                r_valid <= 1'b0;
                r_sad   <= 1'b0;
            end
        end
    end

    assign oValid        = r_valid;
    assign oSAD          = r_sad;
    assign oA2           = 32'(r_lane[0]);
    assign oB2           = 32'(r_lane[1]);
    assign oC2           = 32'(r_lane[2]);
    assign oD2           = 32'(r_lane[3]);
    assign oRowIdx       = r_row_idx;
    assign oRegWriteCtrl = r_reg_write;
    assign oRegDstResult = r_reg_dst;
    assign oPCPlus4      = r_pc_plus4;

endmodule

// File: tb/tb_sad2_absdiff_stage.sv
// tb/tb_sad2_absdiff_stage.sv - directed vector bench for sad2_absdiff_stage
module tb_sad2_absdiff_stage;

    logic        Clk = 1'b0;
    logic        Reset, Stall, Flush, InValid, SADOp;
    logic [31:0] WinA, WinB;
    logic        RegWriteCtrl;
    logic [4:0]  RegDstResult;
    logic [31:0] PCPlus4;

    // Main DUT: 4-row blocks, 16-bit accumulators.
    logic        m_valid, m_sad, m_rw;
    logic [31:0] m_a, m_b, m_c, m_d, m_pc;
    logic [7:0]  m_idx;
    logic [4:0]  m_rd;
    // Wrap/saturate DUT: 2-row blocks, 8-bit accumulators.
    logic        w_valid, w_sad, w_rw;
    logic [31:0] w_a, w_b, w_c, w_d, w_pc;
    logic [7:0]  w_idx;
    logic [4:0]  w_rd;
    // Single-row DUT.
    logic        s_valid, s_sad, s_rw;
    logic [31:0] s_a, s_b, s_c, s_d, s_pc;
    logic [7:0]  s_idx;
    logic [4:0]  s_rd;

    sad2_absdiff_stage #(.BLOCK_ROWS(4), .ACC_W(16)) u_main (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .InValid(InValid), .SADOp(SADOp),
        .WinA(WinA), .WinB(WinB), .RegWriteCtrl(RegWriteCtrl), .RegDstResult(RegDstResult), .PCPlus4(PCPlus4),
        .oValid(m_valid), .oSAD(m_sad), .oA2(m_a), .oB2(m_b), .oC2(m_c), .oD2(m_d), .oRowIdx(m_idx),
        .oRegWriteCtrl(m_rw), .oRegDstResult(m_rd), .oPCPlus4(m_pc));

    sad2_absdiff_stage #(.BLOCK_ROWS(2), .ACC_W(8)) u_wrap (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .InValid(InValid), .SADOp(SADOp),
        .WinA(WinA), .WinB(WinB), .RegWriteCtrl(RegWriteCtrl), .RegDstResult(RegDstResult), .PCPlus4(PCPlus4),
        .oValid(w_valid), .oSAD(w_sad), .oA2(w_a), .oB2(w_b), .oC2(w_c), .oD2(w_d), .oRowIdx(w_idx),
        .oRegWriteCtrl(w_rw), .oRegDstResult(w_rd), .oPCPlus4(w_pc));

    sad2_absdiff_stage #(.BLOCK_ROWS(1), .ACC_W(16)) u_one (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .InValid(InValid), .SADOp(SADOp),
        .WinA(WinA), .WinB(WinB), .RegWriteCtrl(RegWriteCtrl), .RegDstResult(RegDstResult), .PCPlus4(PCPlus4),
        .oValid(s_valid), .oSAD(s_sad), .oA2(s_a), .oB2(s_b), .oC2(s_c), .oD2(s_d), .oRowIdx(s_idx),
        .oRegWriteCtrl(s_rw), .oRegDstResult(s_rd), .oPCPlus4(s_pc));

    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst, fl, st, iv, so;
        logic [31:0] wa, wb;
        logic        e_valid, e_sad;
        logic [31:0] e_a, e_b, e_c, e_d;
        logic [7:0]  e_idx;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;
    int   cur   = 0;

    localparam logic [31:0] WA = 32'h0A141E28;
    localparam logic [31:0] WB = 32'h05191E00;
    localparam logic [31:0] XA = 32'h00FF7F80;
    localparam logic [31:0] XB = 32'hFF00807F;

    task automatic add(input logic rst, fl, st, iv, so, input logic [31:0] wa, wb,
                       input logic ev, es, input logic [31:0] ea, eb, ec, ed, input logic [7:0] ei);
        vec_t v;
        v.rst = rst; v.fl = fl; v.st = st; v.iv = iv; v.so = so; v.wa = wa; v.wb = wb;
        v.e_valid = ev; v.e_sad = es; v.e_a = ea; v.e_b = eb; v.e_c = ec; v.e_d = ed; v.e_idx = ei;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (step %0d): got %0h expected %0h", name, cur, act, exp);
        end
    endtask

    task automatic drive(input logic rst, fl, st, iv, so, input logic [31:0] wa, wb);
        Reset = rst; Flush = fl; Stall = st; InValid = iv; SADOp = so; WinA = wa; WinB = wb;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1; Stall = 1'b0; Flush = 1'b0; InValid = 1'b0; SADOp = 1'b0;
        WinA = '0; WinB = '0; RegWriteCtrl = 1'b0; RegDstResult = '0; PCPlus4 = '0;

        //   rst fl st iv so  wa  wb   valid sad  A    B    C    D   idx
        add(1, 0, 0, 0, 0, WA, WB,   0, 0,   0,   0,   0,   0,   0);
        add(0, 0, 0, 1, 1, WA, WB,   1, 0,   5,   5,   0,  40,   0);
        add(0, 0, 0, 1, 1, WA, WB,   1, 0,  10,  10,   0,  80,   1);
        add(0, 0, 0, 1, 0, WA, WB,   1, 0,   0,   0,   0,   0,   1);
        add(0, 0, 0, 0, 1, WA, WB,   0, 0,   0,   0,   0,   0,   1);
        add(0, 0, 0, 1, 1, WA, WB,   1, 0,  15,  15,   0, 120,   2);
        add(0, 0, 0, 1, 1, WA, WB,   1, 1,  20,  20,   0, 160,   3);
        add(0, 0, 1, 1, 1, WA, WB,   1, 1,  20,  20,   0, 160,   3);
        add(0, 0, 1, 1, 1, WA, WB,   1, 1,  20,  20,   0, 160,   3);
        add(0, 0, 1, 0, 0, WA, WB,   1, 1,  20,  20,   0, 160,   3);
        add(0, 0, 0, 0, 0, WA, WB,   0, 0,  20,  20,   0, 160,   3);
        add(0, 0, 0, 1, 1, WA, WB,   1, 0,   5,   5,   0,  40,   0);
        add(0, 0, 0, 1, 1, WA, WB,   1, 0,  10,  10,   0,  80,   1);
        add(0, 1, 1, 1, 1, WA, WB,   0, 0,   0,   0,   0,   0,   1);
        add(0, 0, 0, 1, 1, WA, WB,   1, 0,   5,   5,   0,  40,   0);
        add(0, 0, 0, 1, 1, WA, WB,   1, 0,  10,  10,   0,  80,   1);
        add(0, 0, 0, 1, 1, WA, WB,   1, 0,  15,  15,   0, 120,   2);
        add(0, 0, 0, 1, 1, WA, WB,   1, 1,  20,  20,   0, 160,   3);
        add(0, 0, 0, 1, 1, WA, WB,   1, 0,   5,   5,   0,  40,   0);
        add(0, 0, 0, 1, 1, WA, WB,   1, 0,  10,  10,   0,  80,   1);
        add(0, 0, 0, 1, 1, WA, WB,   1, 0,  15,  15,   0, 120,   2);
        add(0, 1, 0, 1, 1, WA, WB,   0, 0,   0,   0,   0,   0,   2);
        add(0, 0, 0, 1, 1, WA, WB,   1, 0,   5,   5,   0,  40,   0);
        add(0, 0, 0, 1, 1, WA, WB,   1, 0,  10,  10,   0,  80,   1);
        add(1, 0, 0, 1, 1, WA, WB,   0, 0,   0,   0,   0,   0,   0);
        add(0, 0, 0, 1, 1, WA, WB,   1, 0,   5,   5,   0,  40,   0);
        add(0, 0, 0, 1, 1, WA, WB,   1, 0,  10,  10,   0,  80,   1);
        add(0, 0, 0, 1, 1, WA, WB,   1, 0,  15,  15,   0, 120,   2);
        add(0, 0, 0, 1, 1, WA, WB,   1, 1,  20,  20,   0, 160,   3);
        add(0, 0, 0, 1, 1, XA, XB,   1, 0, 255, 255,   1,   1,   0);
        add(0, 0, 0, 1, 1, WA, WB,   1, 0, 260, 260,   1,  41,   1);

        drive(1, 0, 0, 0, 0, '0, '0);
        drive(1, 0, 0, 0, 0, '0, '0);

        for (int i = 0; i < vecs.size(); i++) begin
            cur = i;
            drive(vecs[i].rst, vecs[i].fl, vecs[i].st, vecs[i].iv, vecs[i].so, vecs[i].wa, vecs[i].wb);
            chk("valid",  32'(m_valid), 32'(vecs[i].e_valid));
            chk("sad",    32'(m_sad),   32'(vecs[i].e_sad));
            chk("laneA",  m_a, vecs[i].e_a);
            chk("laneB",  m_b, vecs[i].e_b);
            chk("laneC",  m_c, vecs[i].e_c);
            chk("laneD",  m_d, vecs[i].e_d);
            chk("rowidx", 32'(m_idx), 32'(vecs[i].e_idx));
        end

        // Passthrough registered on a non-SAD instruction, then held through a stall.
        cur = 100;
        RegWriteCtrl = 1'b1; RegDstResult = 5'h1B; PCPlus4 = 32'h12345678;
        drive(0, 0, 0, 1, 0, WA, WB);
        chk("m_rw", 32'(m_rw), 32'd1);
        chk("m_rd", 32'(m_rd), 32'h1B);
        chk("m_pc", m_pc, 32'h12345678);
        chk("w_pc", w_pc, 32'h12345678);
        chk("w_rw_rd", {26'd0, w_rw, w_rd}, {26'd0, 1'b1, 5'h1B});
        chk("s_pc", s_pc, 32'h12345678);
        chk("s_rw_rd", {26'd0, s_rw, s_rd}, {26'd0, 1'b1, 5'h1B});
        cur = 101;
        RegWriteCtrl = 1'b0; RegDstResult = 5'h04; PCPlus4 = 32'hCAFE0000;
        drive(0, 0, 1, 1, 0, WA, WB);
        chk("m_pc_stall", m_pc, 32'h12345678);
        chk("m_rd_stall", 32'(m_rd), 32'h1B);
        drive(0, 0, 0, 1, 0, WA, WB);
        chk("m_pc_next", m_pc, 32'hCAFE0000);
        chk("m_rw_next", 32'(m_rw), 32'd0);

        // Accumulator overflow at ACC_W=8 and single-row blocks.
        cur = 200;
        drive(1, 0, 0, 0, 0, '0, '0);
        drive(0, 0, 0, 1, 1, 32'hFF000000, 32'h0);
        chk("w_a_row0",  w_a, 32'd255);
        chk("w_sad_row0", 32'(w_sad), 32'd0);
        chk("w_idx_row0", 32'(w_idx), 32'd0);
        chk("s_a_row0",  s_a, 32'd255);
        chk("s_sad_row0", 32'(s_sad), 32'd1);
        cur = 201;
        drive(0, 0, 0, 1, 1, 32'hFF000000, 32'h0);
`ifdef SAD2_SATURATE_EN
        chk("w_a_sat", w_a, 32'd255);
`else
        chk("w_a_wrap", w_a, 32'd254);
`endif
        chk("w_sad_row1", 32'(w_sad), 32'd1);
        chk("w_valid", 32'(w_valid), 32'd1);
        chk("w_idx_row1", 32'(w_idx), 32'd1);
        chk("w_bcd", w_b | w_c | w_d, 32'd0);
        chk("s_a_row1",  s_a, 32'd255);
        chk("s_sad_row1", 32'(s_sad), 32'd1);

        // Absolute value with both subtraction signs, one-row block.
        cur = 300;
        drive(1, 0, 0, 0, 0, '0, '0);
        drive(0, 0, 0, 1, 1, XA, XB);
        chk("s_abs_a", s_a, 32'd255);
        chk("s_abs_b", s_b, 32'd255);
        chk("s_abs_c", s_c, 32'd1);
        chk("s_abs_d", s_d, 32'd1);
        chk("s_abs_sad", 32'(s_sad), 32'd1);
        chk("s_abs_valid", 32'(s_valid), 32'd1);
        chk("s_abs_idx", 32'(s_idx), 32'd0);
        drive(0, 0, 0, 0, 0, XA, XB);
        chk("s_idle_sad", 32'(s_sad), 32'd0);
        chk("s_idle_valid", 32'(s_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
